// File: rtl/mem_bus_arbiter_if.sv
// Bundles the CPU fetch (i_*), CPU data (d_*) and downstream memory (m_*) channels.
// slave: the arbiter's view; master: the environment (CPU + memory) view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] i_addr;
    logic              i_req_valid;
    logic              i_req_ready;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rvalid;
    logic              i_rready;

    logic [ADDR_W-1:0] d_addr;
    logic              d_write;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic              d_read;
    logic              d_req_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;
    logic              d_rready;

    logic [ADDR_W-1:0] m_addr;
    logic              m_write;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic              m_read;
    logic              m_req_ready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rvalid;
    logic              m_rready;

    modport slave (
        input  i_addr, i_req_valid, i_rready,
        input  d_addr, d_write, d_wdata, d_wstrb, d_read, d_rready,
        input  m_req_ready, m_rdata, m_rvalid,
        output i_req_ready, i_rdata, i_rvalid,
        output d_req_ready, d_rdata, d_rvalid,
        output m_addr, m_write, m_wdata, m_wstrb, m_read, m_rready
    );

    modport master (
        output i_addr, i_req_valid, i_rready,
        output d_addr, d_write, d_wdata, d_wstrb, d_read, d_rready,
        output m_req_ready, m_rdata, m_rvalid,
        input  i_req_ready, i_rdata, i_rvalid,
        input  d_req_ready, d_rdata, d_rvalid,
        input  m_addr, m_write, m_wdata, m_wstrb, m_read, m_rready
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between CPU fetch (I) and load/store (D); one transaction in flight.
// Latency: grant, >=1 issue, >=1 response cycle (read best case 3); 1 idle bubble between.
// Backpressure: loser and busy requesters see req_ready=0; m_req_ready/rready stall in place. ARB_RR_EN selects round-robin.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_bus_arbiter_if.slave     bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t            state_q;
    owner_t            owner_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [STRB_W-1:0] m_wstrb_q;
    logic              m_read_q;
    logic              m_write_q;
`ifdef ARB_RR_EN
    owner_t            last_grant_q;
`endif

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic in_idle;
    logic in_resp;
    logic m_rready_c;

    assign i_req   = bus.i_req_valid;
    assign d_req   = bus.d_write | bus.d_read;
    assign in_idle = (state_q == IDLE);
    assign in_resp = (state_q == RESP);

`ifdef ARB_RR_EN
    // On contention the side that did not win last time takes the port.
    assign grant_d = d_req & (~i_req | (last_grant_q == OWN_I));
`else
    assign grant_d = d_req;
`endif
    assign grant_i = i_req & ~grant_d;

    assign bus.i_req_ready = in_idle & grant_i;
    assign bus.d_req_ready = in_idle & grant_d;

    // Outside RESP any response is a leftover and is drained unconditionally.
    assign m_rready_c = in_resp ? ((owner_q == OWN_I) ? bus.i_rready : bus.d_rready) : 1'b1;

    assign bus.m_rready = m_rready_c;
    assign bus.i_rvalid = in_resp & (owner_q == OWN_I) & bus.m_rvalid;
    assign bus.d_rvalid = in_resp & (owner_q == OWN_D) & bus.m_rvalid;
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstrb = m_wstrb_q;
    assign bus.m_read  = m_read_q;
    assign bus.m_write = m_write_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
            m_read_q     <= 1'b0;
            m_write_q    <= 1'b0;
`ifdef ARB_RR_EN
            last_grant_q <= OWN_I;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        // A write with d_read also set is still only a write.
                        owner_q   <= OWN_D;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_write ? bus.d_wdata : '0;
                        m_wstrb_q <= bus.d_write ? bus.d_wstrb : '0;
                        m_write_q <= bus.d_write;
                        m_read_q  <= ~bus.d_write;
                        state_q   <= ISSUE;
`ifdef ARB_RR_EN
                        last_grant_q <= OWN_D;
`endif
                    end else if (grant_i) begin
                        owner_q   <= OWN_I;
                        m_addr_q  <= bus.i_addr;
                        m_wdata_q <= '0;
                        m_wstrb_q <= '0;
                        m_write_q <= 1'b0;
                        m_read_q  <= 1'b1;
                        state_q   <= ISSUE;
`ifdef ARB_RR_EN
                        last_grant_q <= OWN_I;
`endif
                    end
                end
                ISSUE: begin
                    if (bus.m_req_ready) begin
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
                        state_q   <= m_write_q ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (bus.m_rvalid && m_rready_c) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: transaction-level model checked every cycle plus pinned literals.
module tb_mem_bus_arbiter;
    logic clk;
    logic rst;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counters: written only by the compare process.
    int checks = 0;
    int failures = 0;
    int wd_cyc = 0;
    int cnt_mread = 0, cnt_mwrite = 0, cnt_irv = 0, cnt_drv = 0, cnt_rrlow = 0;
    logic [3:0]  wstrb_on_write = 4'h0;
    logic [31:0] wdata_on_write = 32'h0;

    // Written only by the main stimulus thread.
    bit          chk_en = 1'b0;
    bit          done_flag = 1'b0;
    int          stall_cfg = 0;
    int          i_hold_cfg = 0;
    string       lit_name [32];
    logic [31:0] lit_act  [32];
    logic [31:0] lit_exp  [32];
    int          nlit = 0;
    bit          gseq [16];
    logic [31:0] last_i_data = 32'h0;
    logic [31:0] last_d_data = 32'h0;

    // Memory contents seen by reads.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'h2402000A : ~a;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h, required %h", n, a, e);
        end
    endtask

    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
        if (nlit < 32) begin
            lit_name[nlit] = n;
            lit_act[nlit]  = a;
            lit_exp[nlit]  = e;
            nlit++;
        end
    endtask

    // Transaction-level model: none / waiting for issue accept / waiting for response.
    int          m_ph = 0;
    int          m_lg = 1;
    int          m_own = 1;
    bit          m_wr = 1'b0;
    logic [31:0] m_a = 32'h0, m_wd = 32'h0;
    logic [3:0]  m_st = 4'h0;

    always @(negedge clk) begin
        int   win;
        logic ireq, dreq, exp_rr;
        wd_cyc++;
        if (wd_cyc > 40000) begin
            $display("FAIL watchdog: got %0d cycles, required under 40000", wd_cyc);
            $fatal(1, "bench stuck");
        end
        if (done_flag) begin
            for (int k = 0; k < nlit; k++) chk(lit_name[k], lit_act[k], lit_exp[k]);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
        ireq = bus.i_req_valid;
        dreq = bus.d_write | bus.d_read;
        win = 0;
        if (m_ph == 0) begin
            if (ireq && dreq) begin
`ifdef ARB_RR_EN
                win = (m_lg == 1) ? 2 : 1;
`else
                win = 2;
`endif
            end else if (dreq) win = 2;
            else if (ireq) win = 1;
        end
        exp_rr = (m_ph == 2) ? ((m_own == 1) ? bus.i_rready : bus.d_rready) : 1'b1;
        if (chk_en) begin
            chk("i_req_ready", bus.i_req_ready, win == 1);
            chk("d_req_ready", bus.d_req_ready, win == 2);
            chk("m_read", bus.m_read, (m_ph == 1) && !m_wr);
            chk("m_write", bus.m_write, (m_ph == 1) && m_wr);
            chk("m_rready", bus.m_rready, exp_rr);
            chk("i_rvalid", bus.i_rvalid, (m_ph == 2) && (m_own == 1) && bus.m_rvalid);
            chk("d_rvalid", bus.d_rvalid, (m_ph == 2) && (m_own == 2) && bus.m_rvalid);
            if (m_ph == 1) begin
                chk("m_addr", bus.m_addr, m_a);
                chk("m_wstrb", bus.m_wstrb, m_st);
                chk("m_wdata", bus.m_wdata, m_wd);
            end
            if (bus.i_rvalid === 1'b1) chk("i_rdata", bus.i_rdata, bus.m_rdata);
            if (bus.d_rvalid === 1'b1) chk("d_rdata", bus.d_rdata, bus.m_rdata);
            if (bus.m_read === 1'b1)  cnt_mread++;
            if (bus.m_write === 1'b1) begin
                cnt_mwrite++;
                wstrb_on_write = bus.m_wstrb;
                wdata_on_write = bus.m_wdata;
            end
            if (bus.i_rvalid === 1'b1) cnt_irv++;
            if (bus.d_rvalid === 1'b1) cnt_drv++;
            if (bus.m_rvalid === 1'b1 && bus.m_rready === 1'b0) cnt_rrlow++;
        end
        if (rst) begin
            m_ph = 0;
            m_lg = 1;
        end else begin
            case (m_ph)
                0: if (win != 0) begin
                    m_own = win;
                    m_lg  = win;
                    m_wr  = (win == 2) && bus.d_write;
                    m_a   = (win == 2) ? bus.d_addr : bus.i_addr;
                    m_wd  = m_wr ? bus.d_wdata : 32'h0;
                    m_st  = m_wr ? bus.d_wstrb : 4'h0;
                    m_ph  = 1;
                end
                1: if (bus.m_req_ready) m_ph = m_wr ? 0 : 2;
                default: if (bus.m_rvalid && exp_rr) m_ph = 0;
            endcase
        end
    end

    // Memory responder: stalls issue for stall_cfg cycles, answers reads one cycle after accept.
    initial begin
        int          iss;
        bit          pend;
        logic [31:0] pdat;
        iss = 0;
        pend = 1'b0;
        pdat = 32'h0;
        bus.m_req_ready = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if ((bus.m_read | bus.m_write) === 1'b1) begin
                if (bus.m_req_ready) iss = 0;
                else iss++;
            end
            if ((bus.m_rvalid & bus.m_rready) === 1'b1) pend = 1'b0;
            if ((bus.m_read & bus.m_req_ready) === 1'b1) begin
                pend = 1'b1;
                pdat = mem_word(bus.m_addr);
            end
            @(posedge clk);
            #1;
            bus.m_req_ready = (iss >= stall_cfg);
            bus.m_rvalid = pend;
            bus.m_rdata = pend ? pdat : 32'h0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // CPU side: drop each request once granted, wait for its response, optionally re-raise.
    task automatic serve(input int reraise_limit, input int budget, input string tag, output int cyc_o);
        int ng, cyc, hold;
        bit ib, db, dwr, gi, gd, ie, de;
        ng = 0; cyc = 0; hold = 0;
        ib = 1'b0; db = 1'b0; dwr = 1'b0;
        while ((bus.i_req_valid || bus.d_write || bus.d_read || ib || db) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            gi = bus.i_req_valid & bus.i_req_ready;
            gd = (bus.d_write | bus.d_read) & bus.d_req_ready;
            ie = bus.i_rvalid & bus.i_rready;
            de = bus.d_rvalid & bus.d_rready;
            if (bus.i_rvalid && !bus.i_rready) hold++;
            if (gd) dwr = bus.d_write;
            if (ie) last_i_data = bus.i_rdata;
            if (de) last_d_data = bus.d_rdata;
            step();
            if (gi) begin
                bus.i_req_valid = 1'b0;
                ib = 1'b1;
                if (ng < 16) gseq[ng] = 1'b0;
                ng++;
            end
            if (gd) begin
                bus.d_write = 1'b0;
                bus.d_read = 1'b0;
                db = !dwr;
                if (ng < 16) gseq[ng] = 1'b1;
                ng++;
            end
            if (hold >= i_hold_cfg) bus.i_rready = 1'b1;
            if (ie) begin
                ib = 1'b0;
                if (ng < reraise_limit) bus.i_req_valid = 1'b1;
            end
            if (de) begin
                db = 1'b0;
                if (ng < reraise_limit) bus.d_read = 1'b1;
            end
        end
        if (cyc >= budget) lit({tag, "_timeout"}, 32'd0, 32'd1);
        cyc_o = cyc;
    endtask

    initial begin
        int c, s_mr, s_mw, s_irv, s_drv, s_rrl;
        bit found;
        rst = 1'b1;
        bus.i_addr = 32'h0; bus.i_req_valid = 1'b0; bus.i_rready = 1'b1;
        bus.d_addr = 32'h0; bus.d_write = 1'b0; bus.d_wdata = 32'h0;
        bus.d_wstrb = 4'h0; bus.d_read = 1'b0; bus.d_rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        lit("rst_m_addr", bus.m_addr, 32'h0);
        lit("rst_m_wdata", bus.m_wdata, 32'h0);
        lit("rst_m_wstrb", bus.m_wstrb, 32'h0);
        lit("rst_m_read", bus.m_read, 32'h0);
        lit("rst_m_write", bus.m_write, 32'h0);
        lit("rst_rvalids", {bus.i_rvalid, bus.d_rvalid}, 32'h0);
        lit("rst_m_rready", bus.m_rready, 32'h1);
        chk_en = 1'b1;

        // Fetch only.
        s_mr = cnt_mread; s_irv = cnt_irv; s_drv = cnt_drv;
        bus.i_addr = 32'h100; bus.i_req_valid = 1'b1;
        serve(0, 50, "fetch", c);
        lit("fetch_latency", c, 32'd3);
        lit("fetch_data", last_i_data, 32'h2402000A);
        lit("fetch_mread_cycles", cnt_mread - s_mr, 32'd1);
        lit("fetch_i_rvalid_cycles", cnt_irv - s_irv, 32'd1);
        lit("fetch_d_rvalid_cycles", cnt_drv - s_drv, 32'd0);

        // Store with partial strobes.
        s_mw = cnt_mwrite; s_irv = cnt_irv; s_drv = cnt_drv;
        bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF; bus.d_wstrb = 4'b0011; bus.d_write = 1'b1;
        serve(0, 50, "store", c);
        repeat (4) step();
        lit("store_mwrite_cycles", cnt_mwrite - s_mw, 32'd1);
        lit("store_wstrb", wstrb_on_write, 32'h3);
        lit("store_wdata", wdata_on_write, 32'hDEADBEEF);
        lit("store_no_rvalid", (cnt_irv - s_irv) + (cnt_drv - s_drv), 32'd0);

        // Backpressure: 5 stalled issue cycles, 3 cycles of i_rready low.
        s_mr = cnt_mread; s_rrl = cnt_rrlow;
        stall_cfg = 5; i_hold_cfg = 3; bus.i_rready = 1'b0;
        bus.i_addr = 32'h140; bus.i_req_valid = 1'b1;
        serve(0, 80, "bp", c);
        lit("bp_mread_cycles", cnt_mread - s_mr, 32'd6);
        lit("bp_rready_low_cycles", cnt_rrlow - s_rrl, 32'd3);
        lit("bp_data", last_i_data, ~32'h140);
        stall_cfg = 0; i_hold_cfg = 0;
        step();

        // Contention, four rounds from reset.
        do_reset();
        bus.i_addr = 32'h180; bus.d_addr = 32'h280;
        bus.i_req_valid = 1'b1; bus.d_read = 1'b1;
        serve(4, 400, "cont", c);
`ifdef ARB_RR_EN
        lit("cont_grants", {28'h0, gseq[0], gseq[1], gseq[2], gseq[3]}, 32'b1010);
`else
        lit("cont_grants", {28'h0, gseq[0], gseq[1], gseq[2], gseq[3]}, 32'b1111);
`endif
        lit("cont_d_data", last_d_data, ~32'h280);

        // d_write and d_read together: write only.
        s_mr = cnt_mread; s_mw = cnt_mwrite; s_drv = cnt_drv;
        bus.d_addr = 32'h240; bus.d_wdata = 32'h12345678; bus.d_wstrb = 4'hF;
        bus.d_write = 1'b1; bus.d_read = 1'b1;
        serve(0, 50, "both", c);
        repeat (4) step();
        lit("both_mwrite_cycles", cnt_mwrite - s_mw, 32'd1);
        lit("both_mread_cycles", cnt_mread - s_mr, 32'd0);
        lit("both_d_rvalid_cycles", cnt_drv - s_drv, 32'd0);
        lit("both_wstrb", wstrb_on_write, 32'hF);

        // Reset while in RESP, then a stray response in IDLE.
        bus.i_rready = 1'b0;
        bus.i_addr = 32'h300; bus.i_req_valid = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            found = bus.i_req_ready;
        end
        if (!found) lit("rstresp_grant_timeout", 32'd0, 32'd1);
        step();
        bus.i_req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            found = bus.i_rvalid;
        end
        if (!found) lit("rstresp_rvalid_timeout", 32'd0, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_rready = 1'b1;
        lit("stray_present", bus.m_rvalid, 32'h1);
        lit("stray_m_rready", bus.m_rready, 32'h1);
        s_irv = cnt_irv; s_drv = cnt_drv;
        repeat (4) step();
        lit("stray_no_rvalid", (cnt_irv - s_irv) + (cnt_drv - s_drv), 32'd0);
        lit("stray_drained", bus.m_rvalid, 32'h0);
        bus.i_addr = 32'h100; bus.i_req_valid = 1'b1;
        serve(0, 50, "postrst", c);
        lit("postrst_latency", c, 32'd3);
        lit("postrst_data", last_i_data, 32'h2402000A);

        step();
        done_flag = 1'b1;
    end
endmodule
